// File: rtl/mii_phy_rx_sink_pkg.sv
// Shared constants, FSM encoding and small helpers for the MII PHY-side receive sink.
package mii_phy_rx_sink_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [3:0]  NIB_SFD         = 4'hD;
  localparam logic [3:0]  NIB_PRE         = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/mii_phy_rx_sink_crc32_nibble.sv
// Combinational reflected CRC-32 update for one nibble, least significant bit first.
module crc32_nibble
  import mii_phy_rx_sink_pkg::*;
(
  input  logic [3:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  function automatic logic [31:0] shift1(input logic [31:0] c);
    return c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
  endfunction

  assign crc_out = shift1(shift1(shift1(shift1(crc_in ^ {28'd0, data}))));

endmodule

// File: rtl/mii_phy_rx_sink.sv
// MII transmit-path termination: preamble/SFD check, nibble-to-byte assembly, FCS and
// length checking, and a no-backpressure AXI-stream byte output.
module mii_phy_rx_sink
  import mii_phy_rx_sink_pkg::*;
#(
  parameter int MIN_PREAMBLE_NIBBLES = 7,
  parameter int MIN_FRAME_LENGTH     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mii_txd,
  input  logic        mii_tx_en,
  input  logic        mii_tx_er,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        frame_start,
  output logic        err_preamble,
  output logic        err_bad_fcs,
  output logic        err_runt,
  output logic [15:0] good_frame_count
);

  logic [3:0]  txd_r;
  logic        tx_en_r;
  logic        tx_er_r;

  rx_state_t   state_r, state_s;
  logic [3:0]  pre_cnt_r, pre_cnt_s;
  logic        phase_r, phase_s;
  logic [3:0]  low_r, low_s;
  logic [7:0]  held_r, held_s;
  logic        held_vld_r, held_vld_s;
  logic [31:0] crc_r, crc_s;
  logic [15:0] byte_cnt_r, byte_cnt_s;
  logic        err_acc_r, err_acc_s;

  logic [7:0]  tdata_r, tdata_s;
  logic        tvalid_r, tvalid_s;
  logic        tlast_r, tlast_s;
  logic        tuser_r, tuser_s;
  logic        frame_start_r, frame_start_s;
  logic        err_preamble_r, err_preamble_s;
  logic        err_bad_fcs_r, err_bad_fcs_s;
  logic        err_runt_r, err_runt_s;
  logic [15:0] count_r, count_s;

  logic [31:0] crc_mid_s;
  logic [31:0] crc_byte_s;
  logic [7:0]  byte_s;
  logic        bad_fcs_s;
  logic        runt_s;
  logic        user_s;

  // CRC advances only on complete bytes, so a trailing odd nibble never reaches it.
  crc32_nibble u_crc_lo (
    .data    (low_r),
    .crc_in  (crc_r),
    .crc_out (crc_mid_s)
  );

  crc32_nibble u_crc_hi (
    .data    (txd_r),
    .crc_in  (crc_mid_s),
    .crc_out (crc_byte_s)
  );

  assign byte_s    = {txd_r, low_r};
  assign bad_fcs_s = (crc_r != CRC32_RESIDUE);
  assign runt_s    = (byte_cnt_r < 16'(MIN_FRAME_LENGTH));
  assign user_s    = err_acc_r | phase_r | bad_fcs_s | runt_s;

  // Input sampling register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd_r   <= 4'd0;
      tx_en_r <= 1'b0;
      tx_er_r <= 1'b0;
    end else begin
      txd_r   <= mii_txd;
      tx_en_r <= mii_tx_en;
      tx_er_r <= mii_tx_er;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_s        = state_r;
    pre_cnt_s      = pre_cnt_r;
    phase_s        = phase_r;
    low_s          = low_r;
    held_s         = held_r;
    held_vld_s     = held_vld_r;
    crc_s          = crc_r;
    byte_cnt_s     = byte_cnt_r;
    err_acc_s      = err_acc_r;
    tdata_s        = 8'd0;
    tvalid_s       = 1'b0;
    tlast_s        = 1'b0;
    tuser_s        = 1'b0;
    frame_start_s  = 1'b0;
    err_preamble_s = 1'b0;
    err_bad_fcs_s  = 1'b0;
    err_runt_s     = 1'b0;
    count_s        = count_r;

    case (state_r)
      ST_IDLE: begin
        if (!tx_en_r) begin
          state_s = ST_IDLE;
        end else if (txd_r == NIB_PRE) begin
          state_s   = ST_PREAMBLE;
          pre_cnt_s = 4'd1;
        end else begin
          err_preamble_s = 1'b1;
          state_s        = ST_DROP;
        end
      end

      ST_PREAMBLE: begin
        if (!tx_en_r) begin
          err_preamble_s = 1'b1;
          state_s        = ST_IDLE;
        end else if (txd_r == NIB_PRE) begin
          pre_cnt_s = sat_inc4(pre_cnt_r);
        end else if ((txd_r == NIB_SFD) && (pre_cnt_r >= 4'(MIN_PREAMBLE_NIBBLES))) begin
          frame_start_s = 1'b1;
          state_s       = ST_DATA;
          crc_s         = CRC32_INIT;
          byte_cnt_s    = 16'd0;
          phase_s       = 1'b0;
          err_acc_s     = 1'b0;
          held_vld_s    = 1'b0;
        end else begin
          err_preamble_s = 1'b1;
          state_s        = ST_DROP;
        end
      end

      ST_DATA: begin
        if (tx_en_r) begin
          err_acc_s = err_acc_r | tx_er_r;
          if (!phase_r) begin
            low_s   = txd_r;
            phase_s = 1'b1;
          end else begin
            phase_s = 1'b0;
            // One byte is held back so the frame's final byte can carry tlast.
            if (held_vld_r) begin
              tdata_s  = held_r;
              tvalid_s = 1'b1;
            end else begin
              tvalid_s = 1'b0;
            end
            held_s     = byte_s;
            held_vld_s = 1'b1;
            crc_s      = crc_byte_s;
            byte_cnt_s = sat_inc16(byte_cnt_r);
          end
        end else begin
          state_s    = ST_IDLE;
          phase_s    = 1'b0;
          held_vld_s = 1'b0;
          if (held_vld_r) begin
            tdata_s       = held_r;
            tvalid_s      = 1'b1;
            tlast_s       = 1'b1;
            tuser_s       = user_s;
            err_bad_fcs_s = bad_fcs_s;
            err_runt_s    = runt_s;
            count_s       = user_s ? count_r : count_r + 16'd1;
          end else begin
            err_runt_s = 1'b1;
          end
        end
      end

      ST_DROP: begin
        if (!tx_en_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Frame state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      pre_cnt_r      <= 4'd0;
      phase_r        <= 1'b0;
      low_r          <= 4'd0;
      held_r         <= 8'd0;
      held_vld_r     <= 1'b0;
      crc_r          <= 32'd0;
      byte_cnt_r     <= 16'd0;
      err_acc_r      <= 1'b0;
      tdata_r        <= 8'd0;
      tvalid_r       <= 1'b0;
      tlast_r        <= 1'b0;
      tuser_r        <= 1'b0;
      frame_start_r  <= 1'b0;
      err_preamble_r <= 1'b0;
      err_bad_fcs_r  <= 1'b0;
      err_runt_r     <= 1'b0;
      count_r        <= 16'd0;
    end else begin
      state_r        <= state_s;
      pre_cnt_r      <= pre_cnt_s;
      phase_r        <= phase_s;
      low_r          <= low_s;
      held_r         <= held_s;
      held_vld_r     <= held_vld_s;
      crc_r          <= crc_s;
      byte_cnt_r     <= byte_cnt_s;
      err_acc_r      <= err_acc_s;
      tdata_r        <= tdata_s;
      tvalid_r       <= tvalid_s;
      tlast_r        <= tlast_s;
      tuser_r        <= tuser_s;
      frame_start_r  <= frame_start_s;
      err_preamble_r <= err_preamble_s;
      err_bad_fcs_r  <= err_bad_fcs_s;
      err_runt_r     <= err_runt_s;
      count_r        <= count_s;
    end
  end

  assign m_axis_tdata     = tdata_r;
  assign m_axis_tvalid    = tvalid_r;
  assign m_axis_tlast     = tlast_r;
  assign m_axis_tuser     = tuser_r;
  assign frame_start      = frame_start_r;
  assign err_preamble     = err_preamble_r;
  assign err_bad_fcs      = err_bad_fcs_r;
  assign err_runt         = err_runt_r;
  assign good_frame_count = count_r;

endmodule
